mcy_mutant_sequencer: RTL and testbench

- Sequences a mutation-coverage miter in which one reference core (mutsel = 0) runs in lockstep with one mutated copy.
- For each mutant in a requested range, the block:
  - drives the mutant select onto the mutated copy;
  - holds both cores in reset;
  - runs them for a programmable cycle budget while watching the miter's output-mismatch flag;
  - emits a killed/survived result record over a valid/ready stream.
- Sits between the formal/simulation harness and the dual-core miter.

---
 rtl/mcy_mutant_sequencer_pkg.sv | 24 ++
 rtl/mcy_run_timer.sv | 33 +++
 rtl/mcy_mutant_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_mcy_mutant_sequencer.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcy_mutant_sequencer_pkg.sv
// Shared types for the mutation-coverage miter sequencer: FSM states,
// result record layout and default widths.
package mcy_pkg;

    localparam int unsigned MUTSEL_W_DEF     = 8;
    localparam int unsigned CNT_W_DEF        = 16;
    localparam int unsigned RESET_CYCLES_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CRST,
        ST_RUN,
        ST_REPORT,
        ST_NEXT,
        ST_DONE
    } mcy_seq_state_e;

    typedef struct packed {
        logic [MUTSEL_W_DEF-1:0] mutsel;
        logic                    killed;
        logic [CNT_W_DEF-1:0]    cycle;
    } mcy_res_rec_t;

endpackage

// File: rtl/mcy_run_timer.sv
// Up-counter that restarts at 0 on load and flags when it reaches the loaded
// limit; used for both the core-reset hold and the run budget.
module mcy_run_timer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic [CNT_W-1:0] count_o,
    output logic             tc_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] limit_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
            limit_q <= '0;
        end else if (load_i) begin
            count_q <= '0;
            limit_q <= limit_i;
        end else if (en_i) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign count_o = count_q;
    assign tc_o    = (count_q == limit_q);

endmodule

// File: rtl/mcy_mutant_sequencer.sv
// Steps a mutated core through a range of mutant indices against a reference
// core, emitting one killed/survived record per mutant.
module mcy_mutant_sequencer
    import mcy_pkg::*;
#(
    parameter int unsigned MUTSEL_W     = MUTSEL_W_DEF,
    parameter int unsigned CNT_W        = CNT_W_DEF,
    parameter int unsigned RESET_CYCLES = RESET_CYCLES_DEF
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [MUTSEL_W-1:0] first_mut_i,
    input  logic [MUTSEL_W-1:0] num_mut_i,
    input  logic [CNT_W-1:0]    run_len_i,
    input  logic                mismatch_i,
    output logic [MUTSEL_W-1:0] mutsel_o,
    output logic                core_rst_no,
    output logic                run_active_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                res_valid_o,
    input  logic                res_ready_i,
    output logic [MUTSEL_W-1:0] res_mutsel_o,
    output logic                res_killed_o,
    output logic [CNT_W-1:0]    res_cycle_o,
    output logic [MUTSEL_W-1:0] killed_cnt_o
);

    mcy_seq_state_e state_q, state_d;

    logic [MUTSEL_W-1:0] mutsel_q;
    logic [MUTSEL_W-1:0] rem_q;
    logic [CNT_W-1:0]    run_len_q;
    logic                busy_q;
    logic                done_q;
    logic [MUTSEL_W-1:0] res_mutsel_q;
    logic                res_killed_q;
    logic [CNT_W-1:0]    res_cycle_q;
    logic [MUTSEL_W-1:0] killed_cnt_q;

    logic                tmr_load;
    logic                tmr_en;
    logic [CNT_W-1:0]    tmr_limit;
    logic [CNT_W-1:0]    tmr_count;
    logic                tmr_tc;
    logic                last_mut;

    logic [MUTSEL_W-1:0] first_coerced;
    logic [CNT_W-1:0]    run_len_coerced;

    assign first_coerced   = (first_mut_i == '0) ? MUTSEL_W'(1) : first_mut_i;
    assign run_len_coerced = (run_len_i == '0) ? CNT_W'(1) : run_len_i;
    // Never wrap past the top index, even if the requested count runs beyond it.
    assign last_mut        = (rem_q == MUTSEL_W'(1)) || (mutsel_q == '1);
    assign tmr_en          = (state_q == ST_CRST) || (state_q == ST_RUN);

    mcy_run_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (tmr_load),
        .en_i   (tmr_en),
        .limit_i(tmr_limit),
        .count_o(tmr_count),
        .tc_o   (tmr_tc)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tmr_load  = 1'b0;
        tmr_limit = CNT_W'(RESET_CYCLES - 1);
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    tmr_load = 1'b1;
                    state_d  = (num_mut_i == '0) ? ST_DONE : ST_CRST;
                end
            end
            ST_CRST: begin
                if (tmr_tc) begin
                    tmr_load  = 1'b1;
                    tmr_limit = run_len_q - CNT_W'(1);
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                if (mismatch_i || tmr_tc) begin
                    state_d = ST_REPORT;
                end
            end
            ST_REPORT: begin
                if (res_ready_i) begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (last_mut) begin
                    state_d = ST_DONE;
                end else begin
                    tmr_load = 1'b1;
                    state_d  = ST_CRST;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mutsel_q     <= '0;
            rem_q        <= '0;
            run_len_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            res_mutsel_q <= '0;
            res_killed_q <= 1'b0;
            res_cycle_q  <= '0;
            killed_cnt_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        run_len_q    <= run_len_coerced;
                        rem_q        <= num_mut_i;
                        killed_cnt_q <= '0;
                        busy_q       <= 1'b1;
                        if (num_mut_i != '0) begin
                            mutsel_q <= first_coerced;
                        end
                    end
                end
                ST_RUN: begin
                    if (mismatch_i) begin
                        res_mutsel_q <= mutsel_q;
                        res_killed_q <= 1'b1;
                        res_cycle_q  <= tmr_count;
                        if (killed_cnt_q != '1) begin
                            killed_cnt_q <= killed_cnt_q + MUTSEL_W'(1);
                        end
                    end else if (tmr_tc) begin
                        res_mutsel_q <= mutsel_q;
                        res_killed_q <= 1'b0;
                        res_cycle_q  <= run_len_q;
                    end
                end
                ST_NEXT: begin
                    rem_q <= rem_q - MUTSEL_W'(1);
                    if (!last_mut) begin
                        mutsel_q <= mutsel_q + MUTSEL_W'(1);
                    end
                end
                ST_DONE: begin
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    mutsel_q <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    assign mutsel_o     = mutsel_q;
    assign core_rst_no  = (state_q == ST_RUN);
    assign run_active_o = (state_q == ST_RUN);
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign res_valid_o  = (state_q == ST_REPORT);
    assign res_mutsel_o = res_mutsel_q;
    assign res_killed_o = res_killed_q;
    assign res_cycle_o  = res_cycle_q;
    assign killed_cnt_o = killed_cnt_q;

endmodule

// File: tb/tb_mcy_mutant_sequencer.sv
// Directed bench for mcy_mutant_sequencer: one task per scenario, expected
// values worked out by hand from the cycle-level behaviour.
module tb_mcy_mutant_sequencer;
    import mcy_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [7:0]  first_mut_i;
    logic [7:0]  num_mut_i;
    logic [15:0] run_len_i;
    logic        mismatch_i;
    logic [7:0]  mutsel_o;
    logic        core_rst_no;
    logic        run_active_o;
    logic        busy_o;
    logic        done_o;
    logic        res_valid_o;
    logic        res_ready_i;
    logic [7:0]  res_mutsel_o;
    logic        res_killed_o;
    logic [15:0] res_cycle_o;
    logic [7:0]  killed_cnt_o;

    int tests = 0;
    int fails = 0;

    mcy_mutant_sequencer #(
        .MUTSEL_W(8),
        .CNT_W(16),
        .RESET_CYCLES(4)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .first_mut_i (first_mut_i),
        .num_mut_i   (num_mut_i),
        .run_len_i   (run_len_i),
        .mismatch_i  (mismatch_i),
        .mutsel_o    (mutsel_o),
        .core_rst_no (core_rst_no),
        .run_active_o(run_active_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .res_valid_o (res_valid_o),
        .res_ready_i (res_ready_i),
        .res_mutsel_o(res_mutsel_o),
        .res_killed_o(res_killed_o),
        .res_cycle_o (res_cycle_o),
        .killed_cnt_o(killed_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(negedge clk_i);
    endtask

    // Returns at the negedge following the capturing edge (first CRST cycle).
    task automatic do_start(input logic [7:0] f, input logic [7:0] n, input logic [15:0] l);
        first_mut_i = f;
        num_mut_i   = n;
        run_len_i   = l;
        start_i     = 1'b1;
        step();
        start_i     = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        step();
        tests++;
        if ({mutsel_o, core_rst_no, run_active_o, busy_o, done_o, res_valid_o} !== 13'h0) begin
            fails++;
            $display("FAIL reset_ctrl: got %0h expected 0",
                     {mutsel_o, core_rst_no, run_active_o, busy_o, done_o, res_valid_o});
        end
        tests++;
        if ({res_mutsel_o, res_killed_o, res_cycle_o, killed_cnt_o} !== 33'h0) begin
            fails++;
            $display("FAIL reset_rec: got %0h expected 0",
                     {res_mutsel_o, res_killed_o, res_cycle_o, killed_cnt_o});
        end
        rst_i = 1'b0;
        step();
    endtask

    task automatic test_single_survivor();
        mcy_res_rec_t exp;
        exp = '{mutsel: 8'd5, killed: 1'b0, cycle: 16'd10};
        res_ready_i = 1'b1;
        do_start(8'd5, 8'd1, 16'd10);
        for (int i = 0; i < 4; i++) begin
            tests++;
            if ({core_rst_no, run_active_o, busy_o, mutsel_o} !== {3'b001, 8'd5}) begin
                fails++;
                $display("FAIL surv_crst[%0d]: got %0h expected %0h", i,
                         {core_rst_no, run_active_o, busy_o, mutsel_o}, {3'b001, 8'd5});
            end
            step();
        end
        for (int i = 0; i < 10; i++) begin
            tests++;
            if ({core_rst_no, run_active_o, mutsel_o} !== {2'b11, 8'd5}) begin
                fails++;
                $display("FAIL surv_run[%0d]: got %0h expected %0h", i,
                         {core_rst_no, run_active_o, mutsel_o}, {2'b11, 8'd5});
            end
            step();
        end
        tests++;
        if ({res_valid_o, core_rst_no, res_mutsel_o, res_killed_o, res_cycle_o} !== {2'b10, exp}) begin
            fails++;
            $display("FAIL surv_record: got %0h expected %0h",
                     {res_valid_o, core_rst_no, res_mutsel_o, res_killed_o, res_cycle_o}, {2'b10, exp});
        end
        step();
        tests++;
        if ({res_valid_o, done_o} !== 2'b00) begin
            fails++;
            $display("FAIL surv_next: got %0b expected 00", {res_valid_o, done_o});
        end
        step();
        tests++;
        if ({done_o, busy_o} !== 2'b01) begin
            fails++;
            $display("FAIL surv_donestate: got %0b expected 01", {done_o, busy_o});
        end
        step();
        tests++;
        if ({done_o, busy_o, mutsel_o, killed_cnt_o} !== {2'b10, 8'd0, 8'd0}) begin
            fails++;
            $display("FAIL surv_done: got %0h expected %0h",
                     {done_o, busy_o, mutsel_o, killed_cnt_o}, {2'b10, 8'd0, 8'd0});
        end
        step();
        tests++;
        if (done_o !== 1'b0) begin
            fails++;
            $display("FAIL surv_done_pulse: got %0b expected 0", done_o);
        end
    endtask

    task automatic test_early_kill();
        res_ready_i = 1'b1;
        do_start(8'd3, 8'd2, 16'd100);
        repeat (4) step();
        for (int i = 0; i < 7; i++) begin
            tests++;
            if ({run_active_o, mutsel_o} !== {1'b1, 8'd3}) begin
                fails++;
                $display("FAIL kill_run[%0d]: got %0h expected %0h", i, {run_active_o, mutsel_o}, {1'b1, 8'd3});
            end
            step();
        end
        mismatch_i = 1'b1;
        step();
        mismatch_i = 1'b0;
        tests++;
        if ({res_valid_o, res_mutsel_o, res_killed_o, res_cycle_o, killed_cnt_o} !==
            {1'b1, 8'd3, 1'b1, 16'd7, 8'd1}) begin
            fails++;
            $display("FAIL kill_record: got %0h expected %0h",
                     {res_valid_o, res_mutsel_o, res_killed_o, res_cycle_o, killed_cnt_o},
                     {1'b1, 8'd3, 1'b1, 16'd7, 8'd1});
        end
        step();
        step();
        tests++;
        if ({core_rst_no, mutsel_o} !== {1'b0, 8'd4}) begin
            fails++;
            $display("FAIL kill_mutsel4: got %0h expected %0h", {core_rst_no, mutsel_o}, {1'b0, 8'd4});
        end
        repeat (4 + 100) step();
        tests++;
        if ({res_valid_o, res_mutsel_o, res_killed_o, res_cycle_o, killed_cnt_o} !==
            {1'b1, 8'd4, 1'b0, 16'd100, 8'd1}) begin
            fails++;
            $display("FAIL surv2_record: got %0h expected %0h",
                     {res_valid_o, res_mutsel_o, res_killed_o, res_cycle_o, killed_cnt_o},
                     {1'b1, 8'd4, 1'b0, 16'd100, 8'd1});
        end
        repeat (3) step();
        tests++;
        if ({done_o, mutsel_o, killed_cnt_o} !== {1'b1, 8'd0, 8'd1}) begin
            fails++;
            $display("FAIL kill_done: got %0h expected %0h", {done_o, mutsel_o, killed_cnt_o}, {1'b1, 8'd0, 8'd1});
        end
        step();
    endtask

    task automatic test_backpressure();
        res_ready_i = 1'b0;
        do_start(8'd9, 8'd1, 16'd3);
        repeat (4 + 3) step();
        for (int i = 0; i < 20; i++) begin
            tests++;
            if ({res_valid_o, core_rst_no, run_active_o, res_mutsel_o, res_killed_o, res_cycle_o} !==
                {3'b100, 8'd9, 1'b0, 16'd3}) begin
                fails++;
                $display("FAIL bp_hold[%0d]: got %0h expected %0h", i,
                         {res_valid_o, core_rst_no, run_active_o, res_mutsel_o, res_killed_o, res_cycle_o},
                         {3'b100, 8'd9, 1'b0, 16'd3});
            end
            step();
        end
        res_ready_i = 1'b1;
        step();
        tests++;
        if ({res_valid_o, run_active_o} !== 2'b00) begin
            fails++;
            $display("FAIL bp_release: got %0b expected 00", {res_valid_o, run_active_o});
        end
        step();
        step();
        tests++;
        if (done_o !== 1'b1) begin
            fails++;
            $display("FAIL bp_done: got %0b expected 1", done_o);
        end
        step();
    endtask

    task automatic test_boundaries();
        int recs;
        logic [7:0] seen [2];
        logic got_done;
        res_ready_i = 1'b1;
        do_start(8'd0, 8'd1, 16'd2);
        tests++;
        if (mutsel_o !== 8'd1) begin
            fails++;
            $display("FAIL first0_mutsel: got %0d expected 1", mutsel_o);
        end
        repeat (4 + 2) step();
        tests++;
        if ({res_valid_o, res_mutsel_o, res_killed_o, res_cycle_o} !== {1'b1, 8'd1, 1'b0, 16'd2}) begin
            fails++;
            $display("FAIL first0_record: got %0h expected %0h",
                     {res_valid_o, res_mutsel_o, res_killed_o, res_cycle_o}, {1'b1, 8'd1, 1'b0, 16'd2});
        end
        repeat (4) step();

        // Top of index range, run_len 0 coerced to one RUN cycle.
        do_start(8'd254, 8'd5, 16'd0);
        recs = 0;
        got_done = 1'b0;
        for (int i = 0; i < 60 && !got_done; i++) begin
            if (res_valid_o && res_ready_i) begin
                if (recs < 2) seen[recs] = res_mutsel_o;
                recs++;
                tests++;
                if ({res_killed_o, res_cycle_o} !== {1'b0, 16'd1}) begin
                    fails++;
                    $display("FAIL top_rec_cycle: got %0h expected %0h", {res_killed_o, res_cycle_o}, {1'b0, 16'd1});
                end
            end
            if (done_o) got_done = 1'b1;
            step();
        end
        tests++;
        if (!got_done || recs != 2) begin
            fails++;
            $display("FAIL top_count: got done=%0b recs=%0d expected done=1 recs=2", got_done, recs);
        end else begin
            tests++;
            if ({seen[0], seen[1]} !== {8'd254, 8'd255}) begin
                fails++;
                $display("FAIL top_order: got %0h expected fe_ff", {seen[0], seen[1]});
            end
        end

        do_start(8'd7, 8'd0, 16'd5);
        tests++;
        if ({done_o, busy_o, res_valid_o, mutsel_o} !== {3'b010, 8'd0}) begin
            fails++;
            $display("FAIL num0_first: got %0h expected %0h", {done_o, busy_o, res_valid_o, mutsel_o}, {3'b010, 8'd0});
        end
        step();
        tests++;
        if ({done_o, busy_o, res_valid_o, mutsel_o} !== {3'b100, 8'd0}) begin
            fails++;
            $display("FAIL num0_done: got %0h expected %0h", {done_o, busy_o, res_valid_o, mutsel_o}, {3'b100, 8'd0});
        end
        step();
    endtask

    task automatic test_crst_mismatch();
        res_ready_i = 1'b1;
        do_start(8'd20, 8'd1, 16'd5);
        mismatch_i = 1'b1;
        repeat (4) step();
        mismatch_i = 1'b0;
        repeat (5) step();
        tests++;
        if ({res_valid_o, res_mutsel_o, res_killed_o, res_cycle_o, killed_cnt_o} !==
            {1'b1, 8'd20, 1'b0, 16'd5, 8'd0}) begin
            fails++;
            $display("FAIL crst_mm_record: got %0h expected %0h",
                     {res_valid_o, res_mutsel_o, res_killed_o, res_cycle_o, killed_cnt_o},
                     {1'b1, 8'd20, 1'b0, 16'd5, 8'd0});
        end
        repeat (4) step();
    endtask

    task automatic test_async_reset();
        res_ready_i = 1'b1;
        do_start(8'd6, 8'd3, 16'd50);
        repeat (4) step();
        mismatch_i = 1'b1;
        step();
        mismatch_i = 1'b0;
        tests++;
        if (killed_cnt_o !== 8'd1) begin
            fails++;
            $display("FAIL ar_precount: got %0d expected 1", killed_cnt_o);
        end
        repeat (2 + 4 + 3) step();
        tests++;
        if ({run_active_o, mutsel_o} !== {1'b1, 8'd7}) begin
            fails++;
            $display("FAIL ar_in_run: got %0h expected %0h", {run_active_o, mutsel_o}, {1'b1, 8'd7});
        end
        rst_i = 1'b1;
        #1;
        tests++;
        if ({mutsel_o, core_rst_no, run_active_o, busy_o, done_o, res_valid_o,
             res_mutsel_o, res_killed_o, res_cycle_o, killed_cnt_o} !== 46'h0) begin
            fails++;
            $display("FAIL ar_immediate: got %0h expected 0",
                     {mutsel_o, core_rst_no, run_active_o, busy_o, done_o, res_valid_o,
                      res_mutsel_o, res_killed_o, res_cycle_o, killed_cnt_o});
        end
        step();
        rst_i = 1'b0;
        step();
        do_start(8'd10, 8'd1, 16'd2);
        tests++;
        if ({busy_o, mutsel_o, killed_cnt_o} !== {1'b1, 8'd10, 8'd0}) begin
            fails++;
            $display("FAIL ar_restart: got %0h expected %0h", {busy_o, mutsel_o, killed_cnt_o}, {1'b1, 8'd10, 8'd0});
        end
        repeat (4 + 2) step();
        tests++;
        if ({res_valid_o, res_mutsel_o, res_killed_o, res_cycle_o} !== {1'b1, 8'd10, 1'b0, 16'd2}) begin
            fails++;
            $display("FAIL ar_record: got %0h expected %0h",
                     {res_valid_o, res_mutsel_o, res_killed_o, res_cycle_o}, {1'b1, 8'd10, 1'b0, 16'd2});
        end
        repeat (3) step();
        tests++;
        if ({done_o, killed_cnt_o} !== {1'b1, 8'd0}) begin
            fails++;
            $display("FAIL ar_done: got %0h expected %0h", {done_o, killed_cnt_o}, {1'b1, 8'd0});
        end
        step();
    endtask

    initial begin
        rst_i       = 1'b1;
        start_i     = 1'b0;
        first_mut_i = '0;
        num_mut_i   = '0;
        run_len_i   = '0;
        mismatch_i  = 1'b0;
        res_ready_i = 1'b1;
        test_reset();
        test_single_survivor();
        test_early_kill();
        test_backpressure();
        test_boundaries();
        test_crst_mismatch();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
